// File: rtl/usb_pio_pkg.sv
// rtl/usb_pio_pkg.sv - shared constants and types for the USB output PIO
package usb_pio_pkg;

  // Register map offsets (word addresses on the Avalon slave)
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_SET   = 2'd1;
  localparam logic [1:0] ADDR_CLR   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  // Pulse generator states
  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } pulse_state_e;

  // Counter width able to hold PULSE_CYCLES, never narrower than one bit
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles + 1) < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/usb_pulse_timer.sv
// rtl/usb_pulse_timer.sv - self-timed pulse FSM with mask latch and down-counter
module usb_pulse_timer
  import usb_pio_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int PULSE_CYCLES = 50,
  parameter int CNT_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             active_o,
  output logic [WIDTH-1:0] mask_o,
  output logic [CNT_W-1:0] cnt_o
);

  pulse_state_e     state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, mask and counter registers; reset aborts any pulse in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start only from idle with a nonzero mask; starts while active are dropped
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      PS_IDLE: begin
        if (start_i && (|mask_i)) begin
          state_d = PS_ACTIVE;
          mask_d  = mask_i;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end
      end
      PS_ACTIVE: begin
        if (cnt_q == '0) begin
          state_d = PS_IDLE;
          mask_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  assign active_o = (state_q == PS_ACTIVE);
  assign mask_o   = mask_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/usb_out_pio.sv
// rtl/usb_out_pio.sv - Avalon-MM output PIO with set/clear and timed pulse
module usb_out_pio
  import usb_pio_pkg::*;
#(
  parameter int          WIDTH        = 1,
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter int          PULSE_CYCLES = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] out_q;
  logic [31:0]      rdata_q;
  logic             active;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] cnt;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^(writedata >> WIDTH);

  usb_pulse_timer #(
    .WIDTH       (WIDTH),
    .PULSE_CYCLES(PULSE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .start_i (wr && (address == ADDR_PULSE)),
    .mask_i  (wdata),
    .active_o(active),
    .mask_o  (mask),
    .cnt_o   (cnt)
  );

  // Base register next value: plain write, atomic set, atomic clear
  always_comb begin
    base_d = base_q;
    if (wr) begin
      case (address)
        ADDR_DATA: base_d = wdata;
        ADDR_SET:  base_d = base_q | wdata;
        ADDR_CLR:  base_d = base_q & ~wdata;
        default:   base_d = base_q;
      endcase
    end
  end

  // Base and pin registers; pins see the pulse inversion one cycle behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= RESET_VALUE[WIDTH-1:0];
      out_q  <= RESET_VALUE[WIDTH-1:0];
    end else begin
      base_q <= base_d;
      out_q  <= base_q ^ (active ? mask : '0);
    end
  end

  // Registered read mux, sampled every cycle regardless of chipselect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      case (address)
        ADDR_DATA: rdata_q <= 32'(base_q);
        ADDR_SET:  rdata_q <= 32'(out_q);
        ADDR_CLR:  rdata_q <= {31'b0, active};
        default:   rdata_q <= 32'(cnt);
      endcase
    end
  end

  assign readdata = rdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_usb_out_pio.sv
// tb/tb_usb_out_pio.sv - directed self-checking bench for usb_out_pio
module tb_usb_out_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        cs2;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;
  logic [31:0] readdata2;
  logic [3:0]  out_port2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_out_pio #(
    .WIDTH(4), .RESET_VALUE(32'h1), .PULSE_CYCLES(50)
  ) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  usb_out_pio #(
    .WIDTH(4), .RESET_VALUE(32'h0), .PULSE_CYCLES(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2), .out_port(out_port2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic sel2);
    address    = a;
    writedata  = d;
    chipselect = ~sel2;
    cs2        = sel2;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    cs2        = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; cs2 = 1'b0;
    write_n = 1'b1; writedata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out_port), 32'h1);
    check("reset_rd", readdata, 32'h0);
    check("reset_out_p1", 32'(out_port2), 32'h0);
    reset = 1'b0;
    address = 2'd0;
    @(negedge clk);
    check("rd_base_after_reset", readdata, 32'h1);

    bus_write(2'd0, 32'h5, 1'b0);
    check("data_latency", 32'(out_port), 32'h1);
    @(negedge clk);
    check("data_5", 32'(out_port), 32'h5);
    bus_write(2'd1, 32'h2, 1'b0);
    @(negedge clk);
    check("set_2", 32'(out_port), 32'h7);
    bus_write(2'd2, 32'h4, 1'b0);
    @(negedge clk);
    check("clr_4", 32'(out_port), 32'h3);
    bus_write(2'd0, 32'hFFFF_FFF0, 1'b0);
    @(negedge clk);
    check("data_upper_ignored", 32'(out_port), 32'h0);

    // 50-cycle pulse on bit 0, counter readback 49..0
    bus_write(2'd3, 32'h1, 1'b0);
    check("pulse_latency", 32'(out_port), 32'h0);
    address = 2'd3;
    @(negedge clk);
    for (int k = 1; k <= 50; k++) begin
      check($sformatf("pulse_out_%0d", k), 32'(out_port), 32'h1);
      check($sformatf("pulse_cnt_%0d", k), readdata, 32'(50 - k));
      @(negedge clk);
    end
    check("pulse_end_out", 32'(out_port), 32'h0);
    address = 2'd2;
    @(negedge clk);
    check("active_after", readdata, 32'h0);

    // SET during pulse, and an ignored second PULSE
    bus_write(2'd3, 32'h1, 1'b0);
    bus_write(2'd1, 32'h2, 1'b0);
    check("mid_set_n1", 32'(out_port), 32'h1);
    @(negedge clk);
    check("mid_set_n2", 32'(out_port), 32'h3);
    bus_write(2'd3, 32'h4, 1'b0);
    address = 2'd2;
    for (int k = 3; k <= 50; k++) begin
      check($sformatf("mid_out_%0d", k), 32'(out_port), 32'h3);
      if (k >= 4) check($sformatf("mid_active_%0d", k), readdata, 32'h1);
      @(negedge clk);
    end
    check("mid_end_out", 32'(out_port), 32'h2);
    check("mid_end_active", readdata, 32'h0);

    // Zero mask is ignored
    bus_write(2'd3, 32'h0, 1'b0);
    address = 2'd2;
    @(negedge clk);
    @(negedge clk);
    check("mask0_active", readdata, 32'h0);
    check("mask0_out", 32'(out_port), 32'h2);

    // PULSE_CYCLES=1 instance: single-cycle pulse
    bus_write(2'd3, 32'h1, 1'b1);
    check("p1_before", 32'(out_port2), 32'h0);
    @(negedge clk);
    check("p1_pulse", 32'(out_port2), 32'h1);
    @(negedge clk);
    check("p1_after", 32'(out_port2), 32'h0);

    // Asynchronous reset mid-pulse
    bus_write(2'd0, 32'h6, 1'b0);
    bus_write(2'd3, 32'h1, 1'b0);
    repeat (10) @(negedge clk);
    check("pre_reset_out", 32'(out_port), 32'h7);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out", 32'(out_port), 32'h1);
    check("async_reset_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    address = 2'd2;
    @(negedge clk);
    check("post_reset_active", readdata, 32'h0);
    for (int k = 0; k < 60; k++) begin
      check($sformatf("no_residual_%0d", k), 32'(out_port), 32'h1);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
